// File: rtl/imem_if.sv
// Instruction-memory request/response bus: one request channel (req/addr/gnt)
// and one in-order read-data channel (rvalid/rdata).
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, a single output
// register towards decode and a one-entry skid buffer for responses that land while decode stalls.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_if.master      imem,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] opc_reg, opc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] addr_reg, addr_next;
    logic        valid_reg, valid_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_addr_reg, skid_addr_next;
    logic        accept;

    assign accept    = valid_reg && !stall_i;
    assign imem.req  = rst_n && (state_reg == ST_REQ);
    assign imem.addr = pc_reg;
    assign instr_o   = instr_reg;
    assign addr_o    = addr_reg;
    assign valid_o   = valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            opc_reg        <= 32'd0;
            instr_reg      <= 32'd0;
            addr_reg       <= 32'd0;
            valid_reg      <= 1'b0;
            skid_instr_reg <= 32'd0;
            skid_addr_reg  <= 32'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            opc_reg        <= opc_next;
            instr_reg      <= instr_next;
            addr_reg       <= addr_next;
            valid_reg      <= valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_addr_reg  <= skid_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        opc_next        = opc_reg;
        instr_next      = instr_reg;
        addr_next       = addr_reg;
        valid_next      = valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_addr_next  = skid_addr_reg;

        // Consumed with nothing to replace it: data stays, only valid drops.
        if (accept) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            ST_REQ: begin
                if (imem.gnt) begin
                    opc_next   = pc_reg;
                    pc_next    = pc_reg + 32'd4;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    if (!valid_reg || !stall_i) begin
                        instr_next = imem.rdata;
                        addr_next  = opc_reg;
                        valid_next = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        skid_instr_next = imem.rdata;
                        skid_addr_next  = opc_reg;
                        state_next      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    instr_next      = skid_instr_reg;
                    addr_next       = skid_addr_reg;
                    valid_next      = 1'b1;
                    skid_instr_next = 32'd0;
                    skid_addr_next  = 32'd0;
                    state_next      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem.rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase

        // Redirect overrides everything above; a request still in flight
        // (granted now or earlier, not yet answered) must be drained.
        if (redirect_i) begin
            pc_next         = {redirect_pc_i[31:2], 2'b00};
            valid_next      = 1'b0;
            instr_next      = 32'd0;
            addr_next       = 32'd0;
            skid_instr_next = 32'd0;
            skid_addr_next  = 32'd0;
            case (state_reg)
                ST_WAIT:  state_next = imem.rvalid ? ST_REQ : ST_DRAIN;
                ST_REQ:   state_next = imem.gnt ? ST_DRAIN : ST_REQ;
                ST_DRAIN: state_next = imem.rvalid ? ST_REQ : ST_DRAIN;
                default:  state_next = ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with a hand-driven memory, then a
// randomized run against a program-order reference of the accepted instruction stream.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        valid_o;

    imem_if mem ();

    if_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (mem),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_o       (instr_o),
        .addr_o        (addr_o),
        .valid_o       (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Memory responder state for the randomized phase
    logic        pend_v;
    logic [31:0] pend_a;
    int          pend_d;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Word-in-memory model: grants at random, answers 1..3 cycles after the grant.
    task automatic mem_step();
        mem.rvalid = 1'b0;
        mem.rdata  = 32'd0;
        if (pend_v) begin
            if (pend_d == 0) begin
                mem.rvalid = 1'b1;
                mem.rdata  = mem_word(pend_a);
                pend_v     = 1'b0;
            end else begin
                pend_d--;
            end
        end
        mem.gnt = 1'b0;
        if (mem.req && !pend_v && ($urandom % 4 != 0)) begin
            mem.gnt = 1'b1;
            pend_v  = 1'b1;
            pend_a  = mem.addr;
            pend_d  = int'($urandom_range(0, 2));
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        redirect_prev;
        int          accepts;

        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_i = 1'b0;
        mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = 32'd0;
        pend_v = 1'b0; pend_a = 32'd0; pend_d = 0;

        // Reset state
        repeat (3) cyc();
        check("rst_req", 32'(mem.req), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_addr", addr_o, 32'd0);

        // First fetch from RESET_PC, immediate grant, data one cycle later
        rst_n = 1'b1; mem.gnt = 1'b1; #1;
        check("first_req", 32'(mem.req), 32'd1);
        check("first_req_addr", mem.addr, 32'h0);
        cyc(); mem.gnt = 1'b0; mem.rvalid = 1'b1; mem.rdata = 32'h0050_0093; #1;
        check("wait_no_req", 32'(mem.req), 32'd0);
        cyc(); mem.rvalid = 1'b0; #1;
        check("first_valid", 32'(valid_o), 32'd1);
        check("first_instr", instr_o, 32'h0050_0093);
        check("first_addr", addr_o, 32'h0);
        check("next_req_addr", mem.addr, 32'h4);
        $display("xfer addr=%08h instr=%08h", addr_o, instr_o);

        // Stall for 5 cycles while the next response lands in the skid buffer
        stall_i = 1'b1; mem.gnt = 1'b1;
        cyc(); mem.gnt = 1'b0; mem.rvalid = 1'b1; mem.rdata = 32'h00A0_0113; #1;
        check("stall_hold_instr", instr_o, 32'h0050_0093);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem.rvalid = 1'b0; #1;
            check("skid_no_req", 32'(mem.req), 32'd0);
            check("skid_instr_held", instr_o, 32'h0050_0093);
            check("skid_valid_held", 32'(valid_o), 32'd1);
        end
        cyc(); stall_i = 1'b0; #1;
        check("release_addr0", addr_o, 32'h0);
        cyc(); #1;
        check("skid_out_valid", 32'(valid_o), 32'd1);
        check("skid_out_instr", instr_o, 32'h00A0_0113);
        check("skid_out_addr", addr_o, 32'h4);
        $display("xfer addr=%08h instr=%08h", addr_o, instr_o);

        // Grant withheld: request held with a stable address
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("gnt_wait_req", 32'(mem.req), 32'd1);
            check("gnt_wait_addr", mem.addr, 32'h8);
        end
        check("drained_valid", 32'(valid_o), 32'd0);
        mem.gnt = 1'b1;

        // Redirect while waiting: stale response discarded
        cyc(); mem.gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_1002;
        cyc(); redirect_i = 1'b0; #1;
        check("redir_valid", 32'(valid_o), 32'd0);
        check("drain_no_req", 32'(mem.req), 32'd0);
        mem.rvalid = 1'b1; mem.rdata = 32'hDEAD_BEEF;
        cyc(); mem.rvalid = 1'b0; #1;
        check("stale_dropped", 32'(valid_o), 32'd0);
        check("redir_req_addr", mem.addr, 32'h0000_1000);
        check("redir_req", 32'(mem.req), 32'd1);

        // Redirect to 0xC without grant, fetch 0xC, then redirect on the 0x10 grant
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_000C;
        cyc(); redirect_i = 1'b0; mem.gnt = 1'b1; #1;
        check("req_c_addr", mem.addr, 32'hC);
        cyc(); mem.gnt = 1'b0; mem.rvalid = 1'b1; mem.rdata = mem_word(32'hC);
        cyc(); mem.rvalid = 1'b0; #1;
        check("instr_c", instr_o, mem_word(32'hC));
        check("req_10_addr", mem.addr, 32'h10);
        mem.gnt = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
        mem.rvalid = 1'b1; mem.rdata = 32'hBAD0_000C;
        cyc(); mem.gnt = 1'b0; redirect_i = 1'b0; mem.rvalid = 1'b0; #1;
        check("gnt_redir_valid", 32'(valid_o), 32'd0);
        check("gnt_redir_instr", instr_o, 32'd0);
        check("gnt_redir_addr", addr_o, 32'd0);
        check("gnt_redir_noreq", 32'(mem.req), 32'd0);
        mem.rvalid = 1'b1; mem.rdata = mem_word(32'h10);
        cyc(); mem.rvalid = 1'b0; #1;
        check("drain10_valid", 32'(valid_o), 32'd0);
        check("req_80_addr", mem.addr, 32'h80);
        check("req_80", 32'(mem.req), 32'd1);

        // Top-of-memory wrap, with low target bits set
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        cyc(); redirect_i = 1'b0; mem.gnt = 1'b1; #1;
        check("top_req_addr", mem.addr, 32'hFFFF_FFFC);
        cyc(); mem.gnt = 1'b0; mem.rvalid = 1'b1; mem.rdata = 32'hCAFE_F00D;
        cyc(); mem.rvalid = 1'b0; #1;
        check("top_addr_o", addr_o, 32'hFFFF_FFFC);
        check("top_instr_o", instr_o, 32'hCAFE_F00D);
        check("wrap_req_addr", mem.addr, 32'h0);
        $display("xfer addr=%08h instr=%08h", addr_o, instr_o);

        // Reset in the middle of WAIT with a response arriving
        mem.gnt = 1'b1; redirect_pc_i = 32'h0000_0040;
        cyc(); mem.gnt = 1'b0; rst_n = 1'b0; redirect_i = 1'b1;
        mem.rvalid = 1'b1; mem.rdata = 32'h1234_5678;
        cyc(); mem.rvalid = 1'b0; redirect_i = 1'b0; #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_addr", addr_o, 32'd0);
        check("midrst_req", 32'(mem.req), 32'd0);
        check("midrst_pc", mem.addr, 32'h0);
        cyc(); rst_n = 1'b1; #1;
        check("restart_req", 32'(mem.req), 32'd1);
        check("restart_addr", mem.addr, 32'h0);

        // Randomized run against the program-order reference
        rst_n = 1'b0; mem.gnt = 1'b0; mem.rvalid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        pend_v = 1'b0;
        exp_addr = 32'h0;
        redirect_prev = 1'b0;
        accepts = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            mem_step();
            stall_i = ($urandom % 4 == 0);
            redirect_i = ($urandom % 40 == 0);
            if ($urandom % 4 == 0)
                redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc_i = $urandom;
            #1;
            if (redirect_prev)
                check("rnd_redir_valid", 32'(valid_o), 32'd0);
            if (mem.req)
                check("rnd_req_align", {30'd0, mem.addr[1:0]}, 32'd0);
            if (valid_o && !stall_i && !redirect_i) begin
                check("rnd_addr", addr_o, exp_addr);
                check("rnd_instr", instr_o, mem_word(exp_addr));
                $display("xfer addr=%08h instr=%08h", addr_o, instr_o);
                exp_addr = exp_addr + 32'd4;
                accepts++;
            end
            if (redirect_i)
                exp_addr = {redirect_pc_i[31:2], 2'b00};
            redirect_prev = redirect_i;
        end
        redirect_i = 1'b0; stall_i = 1'b0;
        check("rnd_progress", 32'(accepts >= 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001: RESET_PC, 32'h0000_0000, fetch address loaded at reset.
REQ-002: clk  input  1  clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: imem_req_o  output  1  instruction memory request valid.
REQ-005: imem_addr_o  output  32  request address, word aligned.
REQ-006: imem_gnt_i  input  1  request accepted this cycle (qualified by imem_req_o).
REQ-007: imem_rvalid_i  input  1  read data valid, strictly in order, at least 1 cycle after gnt.
REQ-008: imem_rdata_i  input  32  instruction word.
REQ-009: redirect_i  input  1  branch/jump/flush redirect, one-cycle pulse.
REQ-010: redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 00.
REQ-011: stall_i  input  1  decode not accepting; output held.
REQ-012: instr_o  output  32  fetched instruction to IF/ID register.
REQ-013: addr_o  output  32  address of instr_o.
REQ-014: valid_o  output  1  instr_o/addr_o valid; accepted at the edge where valid_o=1 and stall_i=0.

Function
REQ-015: State machine SHALL have states REQ, WAIT, HOLD, DRAIN, and SHALL allow at most one outstanding memory request.
REQ-016: REQ: imem_req_o=1, imem_addr_o=pc; address stable until gnt; on gnt, opc<=pc, pc<=pc+4, go WAIT.
REQ-017: pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018: WAIT: imem_req_o=0; on rvalid, if output register empty or accepted this cycle, load instr_o<=rdata, addr_o<=opc, valid_o<=1, go REQ.
REQ-019: WAIT: on rvalid with valid_o=1 and stall_i=1, capture rdata/opc into a 1-entry skid buffer, go HOLD.
REQ-020: HOLD: imem_req_o=0; when output accepted, move skid to output (valid_o stays 1), clear skid, go REQ.
REQ-021: Output accepted with no new data: valid_o<=0; instr_o/addr_o retain values.
REQ-022: Redirect SHALL take priority over every other event in the same cycle.
REQ-023: Redirect: pc<=redirect_pc_i & ~3, valid_o<=0, instr_o<=0, addr_o<=0, skid cleared.
REQ-024: Redirect next state: from WAIT without rvalid -> DRAIN; from REQ with gnt same cycle -> DRAIN; from WAIT with rvalid same cycle, REQ without gnt, HOLD, or DRAIN -> REQ, except DRAIN without rvalid stays DRAIN.
REQ-025: Redirect SHALL NOT advance pc by 4 even if gnt occurs in the same cycle.
REQ-026: DRAIN: imem_req_o=0; discard the next rvalid data, go REQ.
REQ-027: Instructions SHALL reach instr_o in program order with no duplication or loss absent redirect.
REQ-028: Throughput: with zero stall and rvalid one cycle after gnt, one instruction per 2 cycles.
REQ-029: stall_i SHALL NOT block an outstanding response; the skid buffer absorbs it.

Reset
REQ-030: rst_n=0 at a rising edge SHALL set pc=RESET_PC, state=REQ, skid empty, valid_o=0, instr_o=0, addr_o=0. Reset overrides redirect and any in-flight response.
REQ-031: While rst_n=0, imem_req_o=0; first request at RESET_PC in the first cycle after rst_n rises.
REQ-032: A response arriving after reset for a pre-reset request is outside scope; the memory is reset concurrently.

Verification
REQ-033: Reset release, gnt immediate, rvalid +1 cycle, data 0x00500093 -> valid_o=1, instr_o=0x00500093, addr_o=0x0; next request addr 0x4.
REQ-034: stall_i=1 held 5 cycles with a response arriving -> instr_o unchanged, skid holds new word, no request issued; stall release -> two instructions in order on consecutive accepts.
REQ-035: redirect_i to 0x0000_1002 while in WAIT -> valid_o=0 next cycle, stale response discarded, next imem_addr_o=0x0000_1000.
REQ-036: redirect_i to 0x80 in the same cycle as gnt for 0x10 and rvalid for 0xC -> response 0xC discarded, DRAIN absorbs 0x10, next request 0x80, pc never 0x14.
REQ-037: pc=0xFFFF_FFFC fetched -> addr_o=0xFFFF_FFFC, next request 0x0000_0000.
REQ-038: gnt withheld 3 cycles -> imem_req_o=1 with imem_addr_o stable; rst_n=0 mid-WAIT -> all outputs zero, restart at RESET_PC.
